// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending doubleword stores between EX/MEM and
// the data memory. It drains one entry per free memory cycle, forwards
// exact-address load hits, and stalls loads that partially overlap a pending store.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_ready,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_hit,
    output logic [DATA_W-1:0]            ld_data,
    output logic                         ld_stall,
    input  logic                         mem_busy,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;

    // Push/pop decisions, drain port and next-state for pointers and count
    always_comb begin
        st_ready  = (count_q != CNT_W'(DEPTH));
        push      = st_valid & st_ready & ~reset;
        pop       = (count_q != '0) & ~mem_busy & ~reset;
        mem_write = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;

        if (pop) begin
            mem_addr        = addr_q[head_q];
            mem_wdata       = data_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and valid-bit registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; contents only matter while the valid bit is set
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

    // Load lookup: walk entries oldest to youngest so the youngest exact match wins
    always_comb begin
        logic [PTR_W-1:0]  idx;
        logic [ADDR_W-1:0] diff_a;
        logic [ADDR_W-1:0] diff_b;
        logic              any_hit;
        logic              any_ovl;
        logic [DATA_W-1:0] fwd;
        idx     = '0;
        diff_a  = '0;
        diff_b  = '0;
        any_hit = 1'b0;
        any_ovl = 1'b0;
        fwd     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx    = head_q + PTR_W'(k);
            diff_a = ld_addr - addr_q[idx];
            diff_b = addr_q[idx] - ld_addr;
            if (valid_q[idx]) begin
                if (addr_q[idx] == ld_addr) begin
                    any_hit = 1'b1;
                    fwd     = data_q[idx];
                end else if ((diff_a < ADDR_W'(8)) || (diff_b < ADDR_W'(8))) begin
                    any_ovl = 1'b1;
                end
            end
        end
        ld_stall = ld_valid & ~reset & any_ovl;
        ld_hit   = ld_valid & ~reset & ~any_ovl & any_hit;
        ld_data  = ld_hit ? fwd : '0;
    end

    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the EX/MEM pipeline register and the data memory. It sits directly upstream of the memory's Memory_Address, Write_Data and MemWrite inputs.
- Doubleword (8-byte) stores from the pipeline are queued and drained into memory one per cycle, whenever the memory port is not claimed by a load.
- Loads are checked against pending stores:
  - exact-address matches are forwarded;
  - partial overlaps stall the load until the conflicting store drains.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
ADDR_W, 64, address width in bits
DATA_W, 64, store/load data width in bits (one doubleword)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
st_valid  in  1  store request from the EX/MEM stage (MemWrite)
st_addr  in  ADDR_W  store byte address
st_data  in  DATA_W  store data, little-endian doubleword
st_ready  out  1  buffer can accept a store this cycle; the pipeline stalls when 0
ld_valid  in  1  load lookup from the EX/MEM stage (MemRead)
ld_addr  in  ADDR_W  load byte address
ld_hit  out  1  load fully satisfied from the buffer
ld_data  out  DATA_W  forwarded data; valid when ld_hit=1
ld_stall  out  1  load partially overlaps a pending store and must wait
mem_busy  in  1  memory port used by a load this cycle; inhibits drain
mem_write  out  1  drives the data memory MemWrite
mem_addr  out  ADDR_W  drives the data memory Memory_Address during a drain
mem_wdata  out  DATA_W  drives the data memory Write_Data during a drain
count  out  $clog2(DEPTH+1)  number of valid entries
empty  out  1  count==0

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - head=0, tail=0, count=0, all entry valid bits cleared.
  - While reset=1, mem_write=0, ld_hit=0 and ld_stall=0 are forced combinationally.
  - Pending stores are discarded when reset is asserted mid-drain; no write is issued in the reset cycle.
  - After reset: st_ready=1, empty=1.
- Storage: DEPTH entries of {addr, data}, circular. head=oldest, tail=next free slot. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accept (push):
  - push = st_valid & st_ready, with st_ready = (count != DEPTH).
  - The full condition is strict: no push when full, even if a pop happens in the same cycle.
  - On push, the entry is written at tail and tail advances at the posedge.
- Drain (pop):
  - pop = !empty & !mem_busy & !reset.
  - mem_write = pop. mem_addr and mem_wdata are combinational from the head entry; they are 0 when not popping.
  - The memory commits the write at the same posedge at which head advances.
  - Minimum latency from accept to mem_write is 1 cycle; there is no same-cycle bypass to memory.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- count: +1 on push only, -1 on pop only. It never exceeds DEPTH and never underflows.
- Load check (combinational, evaluated only when ld_valid=1; all outputs are 0 otherwise). Every valid entry is compared, including the head being drained this cycle.
  - exact: e.addr == ld_addr.
  - overlap: e.addr != ld_addr and ((ld_addr - e.addr) mod 2^ADDR_W < 8 or (e.addr - ld_addr) mod 2^ADDR_W < 8).
  - If any entry overlaps, ld_stall=1 and ld_hit=0. A stall takes priority over any exact match.
  - Otherwise, if any entry matches exactly, ld_hit=1 and ld_data is the data of the youngest matching entry (closest to tail).
  - Otherwise ld_hit=0; the load reads memory normally.
- A store accepted in cycle N is not visible to a load lookup in cycle N; it becomes visible from cycle N+1.
- No address range checking: out-of-range addresses are passed through unchanged.
- mem_busy held high indefinitely: the buffer fills, then st_ready=0; no entry is lost or reordered.

Test Plan:
- Reset, then push {addr=0, data=64'h1122334455667788} with mem_busy=0 -> next cycle mem_write=1, mem_addr=0, mem_wdata=64'h1122334455667788; the memory doubleword at address 0 reads back this value; empty=1 afterwards.
- mem_busy=1, push 5 stores to addrs 8,16,24,32,40 -> st_ready=0 after the 4th store, count=4, 5th store not accepted; release mem_busy -> mem_write on 4 consecutive cycles with addrs 8,16,24,32 in order, then empty=1.
- mem_busy=1, push addr=16 data=A, then addr=16 data=B; ld_valid=1, ld_addr=16 -> ld_hit=1, ld_data=B, ld_stall=0.
- Pending store at addr=16, load at ld_addr=20 -> ld_stall=1, ld_hit=0; drop mem_busy -> after the drain cycle ld_stall=0, ld_hit=0.
- Full buffer with a simultaneous push and pop -> push rejected (st_ready=0), count goes 4->3; pointer wrap checked over 10+ push/pop pairs with data equal to addr, memory contents match.
- Assert reset with count=3 while mem_write=1 -> mem_write=0 that cycle; count=0, empty=1, st_ready=1 next cycle; no further memory writes.
